// File: rtl/keyed_alu32.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : keyed_alu32
// Description : 32-bit ALU behind the keyed input multiplexer. A request is a
//               key differing from keyback_o; the key is returned on keyback_o
//               together with result/flags when the operation completes.
//               Single-cycle logic/arithmetic ops, plus 32-iteration
//               shift-add multiply and restoring unsigned divide/remainder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module keyed_alu32 #(
   parameter int unsigned MUL_EN = 1,
   parameter int unsigned DIV_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  op_i,
   input  logic [7:0]  key_i,
   input  logic [31:0] A_i,
   input  logic [31:0] B_i,
   output logic [31:0] result_o,
   output logic [7:0]  keyback_o,
   output logic [4:0]  flags_o,
   output logic        busy_o
);

   localparam logic [7:0] c_OP_NOP  = 8'h00;
   localparam logic [7:0] c_OP_ADD  = 8'h01;
   localparam logic [7:0] c_OP_SUB  = 8'h02;
   localparam logic [7:0] c_OP_AND  = 8'h03;
   localparam logic [7:0] c_OP_OR   = 8'h04;
   localparam logic [7:0] c_OP_XOR  = 8'h05;
   localparam logic [7:0] c_OP_SHL  = 8'h06;
   localparam logic [7:0] c_OP_SHR  = 8'h07;
   localparam logic [7:0] c_OP_SRA  = 8'h08;
   localparam logic [7:0] c_OP_MUL  = 8'h09;
   localparam logic [7:0] c_OP_DIVU = 8'h0A;
   localparam logic [7:0] c_OP_REMU = 8'h0B;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_ITER = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   // Latched request
   logic [7:0]  r_op;
   logic [7:0]  r_key;
   logic [31:0] r_a;
   logic [31:0] r_b;

   // Iterative datapath: r_acc = product accumulator / partial remainder,
   // r_x = shifted multiplicand / dividend-quotient shift register,
   // r_y = shifted multiplier
   logic [31:0] r_acc;
   logic [31:0] r_x;
   logic [31:0] r_y;
   logic [4:0]  r_cnt;

   logic [31:0] r_result;
   logic [7:0]  r_keyback;
   logic [4:0]  r_flags;

   // Single-cycle results
   logic [32:0] w_sum;
   logic [31:0] w_diff;
   logic [31:0] w_sc_res;
   logic        w_sc_c;
   logic        w_sc_v;
   logic        w_sc_err;
   logic        w_is_iter;

   // Iteration step results
   logic        w_is_mul;
   logic [31:0] w_mul_acc_nxt;
   logic [32:0] w_rem_sh;
   logic        w_rem_ge;
   logic [31:0] w_rem_sub;
   logic [31:0] w_rem_nxt;
   logic [31:0] w_quo_nxt;
   logic [31:0] w_it_res;

   // FSM controls
   logic        w_start;
   logic        w_iter_init;
   logic        w_done;
   logic [31:0] w_done_res;
   logic        w_done_c;
   logic        w_done_v;
   logic        w_done_err;
   logic [4:0]  w_done_flags;

   assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
   assign w_diff = r_a - r_b;

   assign w_is_mul      = (r_op == c_OP_MUL);
   assign w_mul_acc_nxt = r_y[0] ? (r_acc + r_x) : r_acc;
   // Restoring division: shift next dividend bit into the partial remainder;
   // the remainder stays below the divisor so the 32-bit subtract is exact
   assign w_rem_sh      = {r_acc, r_x[31]};
   assign w_rem_ge      = (w_rem_sh >= {1'b0, r_b});
   assign w_rem_sub     = w_rem_sh[31:0] - r_b;
   assign w_rem_nxt     = w_rem_ge ? w_rem_sub : w_rem_sh[31:0];
   assign w_quo_nxt     = {r_x[30:0], w_rem_ge};
   assign w_it_res      = w_is_mul ? w_mul_acc_nxt :
                          ((r_op == c_OP_DIVU) ? w_quo_nxt : w_rem_nxt);

   // Single-cycle result/flag decode and selection of iterative ops
   always_comb begin
      w_sc_res  = '0;
      w_sc_c    = 1'b0;
      w_sc_v    = 1'b0;
      w_sc_err  = 1'b0;
      w_is_iter = 1'b0;
      case (r_op)
         c_OP_NOP: w_sc_res = '0;
         c_OP_ADD: begin
            w_sc_res = w_sum[31:0];
            w_sc_c   = w_sum[32];
            w_sc_v   = (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
         end
         c_OP_SUB: begin
            w_sc_res = w_diff;
            w_sc_c   = (r_a < r_b);
            w_sc_v   = (r_a[31] != r_b[31]) && (w_diff[31] != r_a[31]);
         end
         c_OP_AND: w_sc_res = r_a & r_b;
         c_OP_OR:  w_sc_res = r_a | r_b;
         c_OP_XOR: w_sc_res = r_a ^ r_b;
         c_OP_SHL: w_sc_res = r_a << r_b[4:0];
         c_OP_SHR: w_sc_res = r_a >> r_b[4:0];
         c_OP_SRA: w_sc_res = $signed(r_a) >>> r_b[4:0];
         c_OP_MUL: begin
            // Multiply by zero needs no iterations; product is zero
            if (MUL_EN != 0) w_is_iter = (r_b != 32'd0);
            else             w_sc_err  = 1'b1;
         end
         c_OP_DIVU: begin
            if (DIV_EN == 0) begin
               w_sc_err = 1'b1;
            end else if (r_b == 32'd0) begin
               w_sc_res = 32'hFFFF_FFFF;
               w_sc_err = 1'b1;
            end else begin
               w_is_iter = 1'b1;
            end
         end
         c_OP_REMU: begin
            if (DIV_EN == 0) begin
               w_sc_err = 1'b1;
            end else if (r_b == 32'd0) begin
               w_sc_res = r_a;
               w_sc_err = 1'b1;
            end else begin
               w_is_iter = 1'b1;
            end
         end
         default: w_sc_err = 1'b1;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state logic and completion selection
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_iter_init = 1'b0;
      w_done      = 1'b0;
      w_done_res  = '0;
      w_done_c    = 1'b0;
      w_done_v    = 1'b0;
      w_done_err  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (key_i != r_keyback) begin
               w_start     = 1'b1;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (w_is_iter) begin
               w_iter_init = 1'b1;
               w_state_nxt = S_ITER;
            end else begin
               w_done      = 1'b1;
               w_done_res  = w_sc_res;
               w_done_c    = w_sc_c;
               w_done_v    = w_sc_v;
               w_done_err  = w_sc_err;
               w_state_nxt = S_IDLE;
            end
         end
         S_ITER: begin
            if (r_cnt == 5'd31) begin
               w_done      = 1'b1;
               w_done_res  = w_it_res;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_done_flags = {w_done_err, w_done_v, w_done_c, w_done_res[31], (w_done_res == 32'd0)};
   end

   // Request latch, iterative datapath and atomic output update
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_op      <= '0;
         r_key     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_cnt     <= '0;
         r_result  <= '0;
         r_keyback <= '0;
         r_flags   <= '0;
      end else begin
         if (w_start) begin
            r_op  <= op_i;
            r_key <= key_i;
            r_a   <= A_i;
            r_b   <= B_i;
         end
         if (w_iter_init) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_x   <= r_a;
            r_y   <= r_b;
         end
         if (r_state == S_ITER) begin
            r_cnt <= r_cnt + 5'd1;
            if (w_is_mul) begin
               r_acc <= w_mul_acc_nxt;
               r_x   <= r_x << 1;
               r_y   <= r_y >> 1;
            end else begin
               r_acc <= w_rem_nxt;
               r_x   <= w_quo_nxt;
            end
         end
         if (w_done) begin
            r_result  <= w_done_res;
            r_flags   <= w_done_flags;
            r_keyback <= r_key;
         end
      end
   end

   assign result_o  = r_result;
   assign keyback_o = r_keyback;
   assign flags_o   = r_flags;
   assign busy_o    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_keyed_alu32.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_keyed_alu32
// Description : Self-checking bench for keyed_alu32: directed scenarios plus
//               randomized requests against a behavioural reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_keyed_alu32;

   logic        clk;
   logic        rst;
   logic [7:0]  op_i;
   logic [7:0]  key_i;
   logic [31:0] A_i;
   logic [31:0] B_i;
   logic [31:0] result_o;
   logic [7:0]  keyback_o;
   logic [4:0]  flags_o;
   logic        busy_o;

   int n_cmp = 0;
   int n_bad = 0;

   keyed_alu32 #(.MUL_EN(1), .DIV_EN(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_i      (op_i),
      .key_i     (key_i),
      .A_i       (A_i),
      .B_i       (B_i),
      .result_o  (result_o),
      .keyback_o (keyback_o),
      .flags_o   (flags_o),
      .busy_o    (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model from the operation definitions; lat = edges after latch
   function automatic void model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [4:0] f, output int lat);
      logic err, v, c;
      longint unsigned wide;
      longint sa, sb, s;
      err = 1'b0; v = 1'b0; c = 1'b0; lat = 1; r = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         8'h00: r = '0;
         8'h01: begin
            wide = longint'(a) + longint'(b);
            r = wide[31:0]; c = wide[32];
            s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         8'h02: begin
            r = a - b; c = (a < b);
            s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         8'h03: r = a & b;
         8'h04: r = a | b;
         8'h05: r = a ^ b;
         8'h06: r = a << b[4:0];
         8'h07: r = a >> b[4:0];
         8'h08: r = $signed(a) >>> b[4:0];
         8'h09: begin
            wide = longint'(a) * longint'(b);
            r = wide[31:0];
            lat = (b != 0) ? 33 : 1;
         end
         8'h0A: if (b == 0) begin r = 32'hFFFF_FFFF; err = 1'b1; end
                else begin r = a / b; lat = 33; end
         8'h0B: if (b == 0) begin r = a; err = 1'b1; end
                else begin r = a % b; lat = 33; end
         default: err = 1'b1;
      endcase
      f = {err, v, c, r[31], (r == 32'd0)};
   endfunction

   // Called just before the latch edge; checks busy, latency and outputs
   task automatic wait_done(input logic [7:0] key, input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] b, input string tag);
      logic [31:0] er;
      logic [4:0]  ef;
      int          elat;
      int          n;
      model(op, a, b, er, ef, elat);
      @(posedge clk); #1;
      chk({tag, ":busy"}, 32'(busy_o), 32'd1);
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (keyback_o == key) break;
      end
      chk({tag, ":lat"}, n, elat);
      chk({tag, ":res"}, result_o, er);
      chk({tag, ":flg"}, 32'(flags_o), 32'(ef));
      chk({tag, ":key"}, 32'(keyback_o), 32'(key));
      chk({tag, ":idle"}, 32'(busy_o), 32'd0);
   endtask

   task automatic run_req(input logic [7:0] op, input logic [7:0] key, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
      @(negedge clk);
      op_i = op; key_i = key; A_i = a; B_i = b;
      wait_done(key, op, a, b, tag);
   endtask

   logic [7:0]  ops [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                             8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};

   initial begin
      logic [7:0]  key;
      logic [7:0]  op;
      logic [31:0] a, b;
      rst = 1'b0; op_i = 8'h01; key_i = 8'h00; A_i = 32'd5; B_i = 32'd6;

      // Idle key after reset never starts a request
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("idle:key", 32'(keyback_o), 32'd0);
      chk("idle:res", result_o, 32'd0);
      chk("idle:busy", 32'(busy_o), 32'd0);
      chk("idle:flg", 32'(flags_o), 32'd0);

      run_req(8'h01, 8'h01, 32'hFFFF_FFFF, 32'd1, "add_wrap");
      run_req(8'h02, 8'h02, 32'h8000_0000, 32'd1, "sub_ovf");
      run_req(8'h09, 8'h03, 32'h0001_0001, 32'h0001_0001, "mul");
      run_req(8'h0A, 8'h04, 32'd100, 32'd7, "divu");
      run_req(8'h0B, 8'h05, 32'd100, 32'd7, "remu");
      run_req(8'h0A, 8'h06, 32'd100, 32'd0, "divu0");
      run_req(8'h0B, 8'h16, 32'd123, 32'd0, "remu0");
      run_req(8'h42, 8'h07, 32'd1, 32'd2, "illegal");
      run_req(8'h08, 8'h17, 32'h8000_0000, 32'h24, "sra");

      // Reset part-way through a multiply, then restart with the same key
      @(negedge clk);
      op_i = 8'h09; key_i = 8'h08; A_i = 32'h1234_5678; B_i = 32'h9ABC_DEF1;
      @(posedge clk);
      repeat (11) @(posedge clk);
      #1;
      chk("abort:pre_key", 32'(keyback_o), 32'h17);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("abort:key", 32'(keyback_o), 32'd0);
      chk("abort:res", result_o, 32'd0);
      chk("abort:flg", 32'(flags_o), 32'd0);
      chk("abort:busy", 32'(busy_o), 32'd0);
      @(negedge clk); rst = 1'b1;
      wait_done(8'h08, 8'h09, 32'h1234_5678, 32'h9ABC_DEF1, "restart");

      // Randomized requests
      key = 8'h08;
      for (int i = 0; i < 40; i++) begin
         key = key + 8'd1;
         if (key == 8'h00) key = 8'h01;
         case ($urandom_range(0, 9))
            0:       op = 8'($urandom_range(12, 255));
            default: op = ops[$urandom_range(0, 11)];
         endcase
         a = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 40));
            2:       b = a;
            default: b = $urandom;
         endcase
         run_req(op, key, a, b, $sformatf("rnd%0d_op%02h", i, op));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/keyed_alu32.md
Name: keyed_alu32

Overview:
32-bit ALU that sits directly downstream of the keyed input multiplexer. It consumes the multiplexer's op/key/A/B outputs and returns the key of the last completed operation on keyback_o. The multiplexer issues a new request only when keyback matches its current key. Single-cycle logic/arithmetic ops are supported, plus iterative 32-cycle multiply and unsigned divide/remainder.

Parameters:
MUL_EN, 1, 1 = MUL implemented; 0 = op 0x09 treated as illegal
DIV_EN, 1, 1 = DIVU/REMU implemented; 0 = ops 0x0A/0x0B treated as illegal

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (asserted when 0)
op_i  in  8  operation code from keyed mux
key_i  in  8  request key; a new request is a key different from keyback_o
A_i  in  32  operand A
B_i  in  32  operand B
result_o  out  32  result of last completed op
keyback_o  out  8  key of last completed op (handshake return to mux)
flags_o  out  5  {err, V, C, N, Z} of last completed op
busy_o  out  1  1 while a request is latched and not yet completed

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, result_o=0, keyback_o=0x00, flags_o=0, busy_o=0, iteration counter=0. Reset mid-operation aborts it with no completion; keyback_o stays 0x00.
- Key 0x00 is reserved as the idle key. A request with key_i==0x00 is never started after reset.
- States: IDLE, EXEC, ITER.
- IDLE: if key_i != keyback_o, latch op/key/A/B, set busy_o=1, go to EXEC at the same edge (edge k). Otherwise stay. Inputs are not sampled again until the next return to IDLE.
- EXEC, single-cycle ops (and illegal op, divide-by-zero): at edge k+1, write result_o, flags_o and keyback_o=latched key together, busy_o=0, go to IDLE.
- EXEC, MUL/DIVU/REMU with B!=0: initialise shift-add or restoring-divide registers, counter=0, go to ITER.
- ITER: one bit per cycle; counter increments. On the 32nd iteration, result_o/flags_o/keyback_o update together, busy_o=0, go to IDLE. Completion is at edge k+33.
- keyback_o never changes except at a completion edge. result_o/flags_o are never partially updated.
- A new request can be latched on the cycle after completion. Back-to-back single-cycle throughput is one op per 2 cycles.
- Op codes:
  - 0x00 NOP: result=0
  - 0x01 ADD
  - 0x02 SUB: A-B
  - 0x03 AND, 0x04 OR, 0x05 XOR
  - 0x06 SHL: A<<B[4:0]
  - 0x07 SHR: logical right shift by B[4:0]
  - 0x08 SRA: arithmetic right shift by B[4:0]
  - 0x09 MUL: low 32 bits of unsigned product
  - 0x0A DIVU: quotient
  - 0x0B REMU: remainder
- Any other op: result=0, err=1, single-cycle.
- Divide by zero: DIVU result=0xFFFFFFFF, REMU result=A, err=1, single-cycle completion.
- Flags:
  - Z = (result==0)
  - N = result[31]
  - C = carry-out for ADD; borrow (A<B unsigned) for SUB; 0 otherwise
  - V = signed overflow for ADD/SUB; 0 otherwise
  - err as above
- All arithmetic is modulo 2^32.
- If key_i or op_i change while busy, the change is ignored until IDLE. At IDLE, the request is started if key_i != keyback_o.

Test Plan:
1. Reset hold then release, key_i=0x00, op ADD -> no start, keyback_o=0x00, result_o=0, busy_o=0 indefinitely.
2. key=0x01, ADD A=0xFFFFFFFF B=1 -> edge k+1: result_o=0, flags Z=1 C=1 V=0, keyback_o=0x01. Then key=0x02, SUB A=0x80000000 B=1 -> result_o=0x7FFFFFFF, V=1, C=0.
3. key=0x03, MUL A=0x00010001 B=0x00010001 -> busy_o high 33 cycles, keyback_o unchanged until edge k+33, then result_o=0x00020001, keyback_o=0x03.
4. key=0x04, DIVU A=100 B=7 -> result_o=14 at k+33. key=0x05, REMU A=100 B=7 -> 2. key=0x06, DIVU B=0 -> result_o=0xFFFFFFFF, err=1 at k+1.
5. key=0x07, op=0x42 -> result_o=0, err=1, keyback_o=0x07. Then SRA A=0x80000000 B=0x24 (shift 4) -> 0xF8000000, N=1.
6. MUL in flight (key 0x08), rst=0 at iteration 10 -> next edge all outputs 0, keyback_o=0x00. After release with key_i still 0x08 -> MUL restarts and completes 33 cycles later.
